rfsoc_chn_reg: RTL
==================

# rfsoc_chn_reg

Parametrised per-channel control/status register file for the RFSoC capture/playback datapath; the successor to the fixed single-DAC/single-ADC register block. It decodes the AXI-Lite-side register bus (wren/offset/wdata/wstrb, plus a registered read port) into NUM_CHN identical channel banks. Each bank provides:
- start address and size registers;
- a self-clearing start pulse and a level reset;
- busy tracking, sticky write-1-to-clear done/timeout status, and a combined interrupt.

## Interface
Parameters:
- NUM_CHN, 4: number of channel banks, legal range 1..8.
- TO_W, 24: width of the per-channel timeout counter and limit register (8..32).

Ports:
- clk  in  1  register-bus clock.
- rstb  in  1  reset, asynchronous, active-low.
- wren  in  1  write strobe, one cycle per write.
- rden  in  1  read strobe, one cycle per read.
- offset  in  16  byte address, word aligned (offset[1:0] ignored).
- wdata  in  32  write data.
- wstrb  in  4  byte enables for wdata.
- rdata  out  32  read data, registered.
- rvalid  out  1  one-cycle pulse qualifying rdata.
- chn_start_addr  out  32*NUM_CHN  channel n occupies bits [32n+31:32n].
- chn_cap_size  out  32*NUM_CHN  same packing.
- chn_reset  out  NUM_CHN  level reset per channel.
- chn_start  out  NUM_CHN  one-cycle start pulse per channel.
- chn_done  in  NUM_CHN  completion pulse from the datapath, synchronous to clk.
- irq  out  1  registered interrupt, active-high level.

## Operation
- Global map:
  - 0x000 ID, RO = 32'h5246_0200 | NUM_CHN.
  - 0x004 IRQ status, RO, bit n = channel n pending.
  - 0x008 timeout limit, RW, TO_W bits, byte-strobed; reset value 0.
  - 0x00C start-all, WO, reads 0; writing bit n = 1 with wstrb[0] issues a start on channel n.
- Channel n base = 0x100 + 0x10*n:
  - +0x0 start_addr, RW, byte-strobed.
  - +0x4 cap_size, RW, byte-strobed.
  - +0x8 ctrl, gated by wstrb[0]:
    - bit0 start: write 1 issues a start; always reads 0.
    - bit1 reset: RW level.
    - bit2 irq_en: RW.
  - +0xC status:
    - bit0 done: sticky, W1C.
    - bit1 busy: RO.
    - bit2 timeout: sticky, W1C.
  - W1C writes are gated by wstrb[0].
- Start request (ctrl.bit0 or start-all):
  - Accepted only when busy = 0 and reset = 0.
  - Acceptance produces chn_start high for exactly one cycle and sets busy.
  - A rejected request produces no pulse and changes no state.
- chn_done = 1:
  - Sets done and clears busy, whether or not busy was set.
  - Same-cycle W1C of done: the set wins.
- reset = 1: chn_reset high, busy forced 0, starts suppressed; sticky bits unaffected.
- Unmapped offsets, and channels ≥ NUM_CHN: reads return 0, writes are ignored.
- Pending for channel n = (done | timeout) & irq_en. IRQ status bit n = pending n. irq = registered OR of all pending bits.
- Reset values:
  - all registers, status bits, rdata and rvalid are 0;
  - chn_start, chn_reset and irq are 0.

## Timing
- Write at edge k:
  - register contents change at edge k;
  - chn_start is high during cycle k+1 only;
  - busy reads 1 for any read issued from cycle k+1 on.
- chn_done sampled high at edge k: done/busy update at edge k, irq high after edge k+1.
- Reads: rden at edge k → rdata/rvalid valid after edge k, for one cycle. rdata holds its value until the next read.
- Same-cycle wren and rden to the same offset: the read returns the pre-write value.
- Same-cycle chn_done and start request on one channel: done is processed first. busy ends at 1 and a start pulse is issued; done is set.
- Asserting rstb mid-operation clears everything immediately. chn_start must not glitch high.

## Configuration
- RFSOC_CHN_TIMEOUT_EN defined:
  - Each channel has a TO_W-bit counter: cleared on start acceptance, incremented while busy.
  - When counter == limit and limit != 0: set timeout and clear busy on that edge.
  - limit = 0 disables timeout.
- Undefined:
  - No counters are built.
  - 0x008 reads 0 and ignores writes.
  - status.bit2 reads 0.

## Test plan
- Reset, then read 0x000 with NUM_CHN=4 → 32'h5246_0204. Read every channel register → 0. irq=0.
- Write 32'hDEAD_BEEF to 0x110 with wstrb=4'b0101, after it held 32'h1122_3344 → readback 32'h11AD_33EF. chn_start_addr[63:32] matches.
- Write 0x128 = 32'h5 (start + irq_en) → chn_start[2] is one cycle wide, and 0x12C reads 32'h2. Pulse chn_done[2] → 0x12C reads 32'h1, 0x004 reads 32'h4, irq=1. Write 0x12C = 1 → irq drops one cycle later.
- Start channel 0, then write ctrl start again while busy → no second pulse. Write 0x00C = 32'hF → pulses only on channels 1..3.
- Pulse chn_done[1] in the same cycle as a W1C to 0x11C → done remains 1.
- With RFSOC_CHN_TIMEOUT_EN and limit=10, start channel 3 without done → timeout set, busy cleared 10 cycles after the start edge. irq=1 if irq_en.

Source files
------------

// File: rtl/rfsoc_chn_reg.sv
// rfsoc_chn_reg: per-channel control/status register file; optional timeout logic under RFSOC_CHN_TIMEOUT_EN
module rfsoc_chn_reg #(
  parameter int NUM_CHN = 4,
  parameter int TO_W    = 24
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   wren,
  input  logic                   rden,
  input  logic [15:0]            offset,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic [31:0]            rdata,
  output logic                   rvalid,
  output logic [32*NUM_CHN-1:0]  chn_start_addr,
  output logic [32*NUM_CHN-1:0]  chn_cap_size,
  output logic [NUM_CHN-1:0]     chn_reset,
  output logic [NUM_CHN-1:0]     chn_start,
  input  logic [NUM_CHN-1:0]     chn_done,
  output logic                   irq
);
  localparam logic [31:0] ID = 32'h5246_0200 | 32'(NUM_CHN);

  function automatic logic [31:0] f_strb(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) f_strb[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
  endfunction

  logic [1:0]         w_reg;
  logic               w_gwr, w_all, w_unused;
  logic [TO_W-1:0]    w_limit;
  logic [31:0]        w_addr [NUM_CHN];
  logic [31:0]        w_size [NUM_CHN];
  logic [NUM_CHN-1:0] w_ien, w_done, w_busy, w_to, w_pend;
  logic [31:0]        w_rd;
  logic [31:0]        r_rdata;
  logic               r_rvalid, r_irq;

  assign w_reg    = offset[3:2];
  assign w_unused = ^offset[1:0];
  assign w_gwr    = wren && offset[15:4] == 12'h000;
  assign w_all    = w_gwr && w_reg == 2'd3 && wstrb[0];
  assign w_pend   = (w_done | w_to) & w_ien;

`ifdef RFSOC_CHN_TIMEOUT_EN
  logic [TO_W-1:0] r_limit;
  logic [31:0]     w_lim_wr;
  assign w_lim_wr = f_strb(32'(r_limit), wdata, wstrb);
  // shared timeout limit, byte-strobed
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) r_limit <= '0;
    else if (w_gwr && w_reg == 2'd2) r_limit <= w_lim_wr[TO_W-1:0];
  assign w_limit = r_limit;
`else
  assign w_limit = '0;
`endif

  genvar n;
  generate
    for (n = 0; n < NUM_CHN; n++) begin : g_chn
      logic [31:0] r_addr, r_size;
      logic        r_rst, r_ien, r_done, r_busy, r_start;
      logic        w_sel, w_ctl, w_w1c, w_req, w_rst_n, w_acc, w_hit, w_to_n;
      assign w_sel   = wren && offset[15:8] == 8'h01 && offset[7:4] == 4'(n);
      assign w_ctl   = w_sel && w_reg == 2'd2 && wstrb[0];
      assign w_w1c   = w_sel && w_reg == 2'd3 && wstrb[0];
      assign w_req   = (w_ctl && wdata[0]) || (w_all && wdata[n]);
      assign w_rst_n = w_ctl ? wdata[1] : r_rst;
      // done and timeout free the channel before a same-cycle start is judged
      assign w_acc   = w_req && !r_rst && !w_rst_n && !(r_busy && !chn_done[n] && !w_hit);
`ifdef RFSOC_CHN_TIMEOUT_EN
      logic [TO_W-1:0] r_cnt;
      logic            r_to;
      assign w_hit  = r_busy && w_limit != '0 && r_cnt + TO_W'(1) == w_limit;
      assign w_to_n = w_hit || (r_to && !(w_w1c && wdata[2]));
      // busy-cycle counter and sticky timeout flag
      always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
          r_cnt <= '0;
          r_to  <= 1'b0;
        end else begin
          r_cnt <= w_acc ? '0 : r_busy ? r_cnt + TO_W'(1) : r_cnt;
          r_to  <= w_to_n;
        end
      assign w_to[n] = r_to;
`else
      assign w_hit   = 1'b0;
      assign w_to_n  = 1'b0;
      assign w_to[n] = w_to_n;
`endif
      // channel registers, sticky done, busy tracking and start pulse
      always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
          r_addr  <= '0;
          r_size  <= '0;
          r_rst   <= 1'b0;
          r_ien   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_start <= 1'b0;
        end else begin
          if (w_sel && w_reg == 2'd0) r_addr <= f_strb(r_addr, wdata, wstrb);
          if (w_sel && w_reg == 2'd1) r_size <= f_strb(r_size, wdata, wstrb);
          if (w_ctl) {r_ien, r_rst} <= wdata[2:1];
          r_done  <= chn_done[n] || (r_done && !(w_w1c && wdata[0]));
          r_busy  <= !w_rst_n && (w_acc || (r_busy && !chn_done[n] && !w_hit));
          r_start <= w_acc;
        end
      assign w_addr[n] = r_addr;
      assign w_size[n] = r_size;
      assign w_ien[n]  = r_ien;
      assign w_done[n] = r_done;
      assign w_busy[n] = r_busy;
      assign chn_start_addr[32*n +: 32] = r_addr;
      assign chn_cap_size[32*n +: 32]   = r_size;
      assign chn_reset[n] = r_rst;
      assign chn_start[n] = r_start;
    end
  endgenerate

  // read decode; unmapped and absent channels return 0
  always_comb begin
    w_rd = '0;
    if (offset[15:4] == 12'h000)
      w_rd = w_reg == 2'd0 ? ID : w_reg == 2'd1 ? 32'(w_pend) : w_reg == 2'd2 ? 32'(w_limit) : '0;
    for (int c = 0; c < NUM_CHN; c++)
      if (offset[15:8] == 8'h01 && offset[7:4] == 4'(c))
        w_rd = w_reg == 2'd0 ? w_addr[c] : w_reg == 2'd1 ? w_size[c] :
               w_reg == 2'd2 ? {29'd0, w_ien[c], chn_reset[c], 1'b0} :
               {29'd0, w_to[c], w_busy[c], w_done[c]};
  end

  // registered read port and interrupt
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (rden) r_rdata <= w_rd;
      r_rvalid <= rden;
      r_irq    <= |w_pend;
    end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign irq    = r_irq;
endmodule
